// File: rtl/ex_mem_pipe_pkg.sv
`default_nettype none
// ============================================================================
// ex_mem_pipe_pkg : shared ALU opcodes, branch condition codes, flag layout
// Revision 1.0
// ============================================================================
package ex_mem_pipe_pkg;

    // ALU operation encodings used by the EX stage
    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SHL = 4'h5,
        OP_SHR = 4'h6,
        OP_MOV = 4'h7
    } aluOp_e;

    // Branch condition codes
    localparam logic [2:0] c_COND_NEQ    = 3'b000;
    localparam logic [2:0] c_COND_EQ     = 3'b001;
    localparam logic [2:0] c_COND_GT     = 3'b010;
    localparam logic [2:0] c_COND_LT     = 3'b011;
    localparam logic [2:0] c_COND_GTE    = 3'b100;
    localparam logic [2:0] c_COND_LTE    = 3'b101;
    localparam logic [2:0] c_COND_OVFL   = 3'b110;
    localparam logic [2:0] c_COND_UNCOND = 3'b111;

    // Bit positions inside the {N,Z,V} flag register
    localparam int c_FLAG_N = 2;
    localparam int c_FLAG_Z = 1;
    localparam int c_FLAG_V = 0;

    localparam int c_DATA_W = 16;
    localparam int c_REG_W  = 4;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pipeState_e;

endpackage : ex_mem_pipe_pkg
`default_nettype wire

// File: rtl/ex_mem_pipe_if.sv
`default_nettype none
// ============================================================================
// ex_mem_pipe_if : EX-side inputs and MEM-side outputs of the EX/MEM register
// Revision 1.0
// ============================================================================
interface ex_mem_pipe_if;

    // EX stage -> pipe register
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [15:0] alu_dst;
    logic        alu_N;
    logic        alu_Z;
    logic        alu_V;
    logic        is_branch;
    logic [2:0]  cond;
    logic [15:0] br_target;
    logic [3:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        hlt;
    logic [15:0] mem_wdata;

    // pipe register -> MEM stage / fetch / ALU
    logic [2:0]  flags;
    logic        out_valid;
    logic [15:0] result;
    logic [3:0]  out_rd;
    logic        out_reg_we;
    logic        out_mem_re;
    logic        out_mem_we;
    logic [15:0] out_wdata;
    logic        branch_taken;
    logic [15:0] branch_pc;
    logic        halted;

    modport master (
        output stall, flush, in_valid, alu_dst, alu_N, alu_Z, alu_V,
               is_branch, cond, br_target, rd, reg_we, mem_re, mem_we,
               hlt, mem_wdata,
        input  flags, out_valid, result, out_rd, out_reg_we, out_mem_re,
               out_mem_we, out_wdata, branch_taken, branch_pc, halted
    );

    modport slave (
        input  stall, flush, in_valid, alu_dst, alu_N, alu_Z, alu_V,
               is_branch, cond, br_target, rd, reg_we, mem_re, mem_we,
               hlt, mem_wdata,
        output flags, out_valid, result, out_rd, out_reg_we, out_mem_re,
               out_mem_we, out_wdata, branch_taken, branch_pc, halted
    );

endinterface : ex_mem_pipe_if
`default_nettype wire

// File: rtl/ex_mem_pipe_br_cond.sv
`default_nettype none
// ============================================================================
// br_cond : combinational branch condition evaluation against {N,Z,V}
// Revision 1.0
// ============================================================================
module br_cond
    import ex_mem_pipe_pkg::*;
(
    input  wire logic [2:0] cond,
    input  wire logic [2:0] flags,
    output logic            take
);

    logic w_n;
    logic w_z;
    logic w_v;

    assign w_n = flags[c_FLAG_N];
    assign w_z = flags[c_FLAG_Z];
    assign w_v = flags[c_FLAG_V];

    always_comb begin
        take = 1'b0;
        case (cond)
            c_COND_NEQ:    take = ~w_z;
            c_COND_EQ:     take = w_z;
            c_COND_GT:     take = ~w_z & ~w_n;
            c_COND_LT:     take = w_n;
            c_COND_GTE:    take = w_z | ~w_n;
            c_COND_LTE:    take = w_n | w_z;
            c_COND_OVFL:   take = w_v;
            c_COND_UNCOND: take = 1'b1;
            default:       take = 1'b0;
        endcase
    end

endmodule : br_cond
`default_nettype wire

// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
// ex_mem_pipe : EX/MEM single-entry pipeline register, flag register,
//               branch resolution and RUN/HALT control
// Revision 1.0
// ============================================================================
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    ex_mem_pipe_if.slave   bus
);

    pipeState_e            r_state;
    logic [2:0]            r_flags;
    logic                  r_valid;
    logic [c_DATA_W-1:0]   r_result;
    logic [c_DATA_W-1:0]   r_wdata;
    logic [c_DATA_W-1:0]   r_brPc;
    logic [c_REG_W-1:0]    r_rd;
    logic                  r_regWe;
    logic                  r_memRe;
    logic                  r_memWe;
    logic                  r_brTaken;
    logic                  r_halted;

    logic                  w_take;
    logic                  w_accept;
    logic                  w_load;

    // Condition is judged on the flags held before this edge, not the
    // branch instruction's own ALU flags.
    br_cond u_br_cond (
        .cond  (bus.cond),
        .flags (r_flags),
        .take  (w_take)
    );

    assign w_accept = bus.in_valid & ~bus.flush;
    // A flush overrides a stall so the entry is still replaced by a bubble.
    assign w_load   = ~bus.stall | bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_flags   <= 3'b000;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_wdata   <= '0;
            r_brPc    <= '0;
            r_rd      <= '0;
            r_regWe   <= 1'b0;
            r_memRe   <= 1'b0;
            r_memWe   <= 1'b0;
            r_brTaken <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_load) begin
                        r_valid   <= w_accept;
                        r_result  <= bus.alu_dst;
                        r_wdata   <= bus.mem_wdata;
                        r_brPc    <= bus.br_target;
                        r_rd      <= bus.rd;
                        r_regWe   <= w_accept & bus.reg_we;
                        r_memRe   <= w_accept & bus.mem_re;
                        r_memWe   <= w_accept & bus.mem_we;
                        r_brTaken <= w_accept & bus.is_branch & w_take;
                        if (w_accept) begin
                            r_flags[c_FLAG_N] <= bus.alu_N;
                            r_flags[c_FLAG_Z] <= bus.alu_Z;
                            r_flags[c_FLAG_V] <= bus.alu_V;
                        end
                        if (w_accept & bus.hlt) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                    end else begin
                        // Held entry: the redirect was already issued once.
                        r_brTaken <= 1'b0;
                    end
                end
                ST_HALT: begin
                    r_valid   <= 1'b0;
                    r_regWe   <= 1'b0;
                    r_memRe   <= 1'b0;
                    r_memWe   <= 1'b0;
                    r_brTaken <= 1'b0;
                    r_halted  <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.flags        = r_flags;
    assign bus.out_valid    = r_valid;
    assign bus.result       = r_result;
    assign bus.out_rd       = r_rd;
    assign bus.out_reg_we   = r_regWe;
    assign bus.out_mem_re   = r_memRe;
    assign bus.out_mem_we   = r_memWe;
    assign bus.out_wdata    = r_wdata;
    assign bus.branch_taken = r_brTaken;
    assign bus.branch_pc    = r_brPc;
    assign bus.halted       = r_halted;

endmodule : ex_mem_pipe
`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
`default_nettype none
// ============================================================================
// tb_ex_mem_pipe : directed self-checking bench for ex_mem_pipe
// Revision 1.0
// ============================================================================
module tb_ex_mem_pipe;

    logic clk;
    logic rst;
    int   nTests;
    int   nFail;

    ex_mem_pipe_if bus ();

    ex_mem_pipe u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearIn();
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_dst   = 16'h0000;
        bus.alu_N     = 1'b0;
        bus.alu_Z     = 1'b0;
        bus.alu_V     = 1'b0;
        bus.is_branch = 1'b0;
        bus.cond      = 3'b000;
        bus.br_target = 16'h0000;
        bus.rd        = 4'h0;
        bus.reg_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.hlt       = 1'b0;
        bus.mem_wdata = 16'h0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setAluFlags(input logic [2:0] f);
        bus.alu_N = f[2];
        bus.alu_Z = f[1];
        bus.alu_V = f[0];
    endtask

    task automatic aluOp(input logic [15:0] res, input logic [2:0] f, input logic [3:0] dst);
        clearIn();
        bus.in_valid = 1'b1;
        bus.alu_dst  = res;
        bus.reg_we   = 1'b1;
        bus.rd       = dst;
        setAluFlags(f);
    endtask

    task automatic branchOp(input logic [2:0] c, input logic [15:0] tgt, input logic [2:0] f);
        clearIn();
        bus.in_valid  = 1'b1;
        bus.is_branch = 1'b1;
        bus.cond      = c;
        bus.br_target = tgt;
        setAluFlags(f);
    endtask

    task automatic checkReset(input string tag);
        check({tag, " out_valid"},    32'(bus.out_valid),    32'h0);
        check({tag, " flags"},        32'(bus.flags),        32'h0);
        check({tag, " result"},       32'(bus.result),       32'h0);
        check({tag, " out_wdata"},    32'(bus.out_wdata),    32'h0);
        check({tag, " branch_pc"},    32'(bus.branch_pc),    32'h0);
        check({tag, " out_rd"},       32'(bus.out_rd),       32'h0);
        check({tag, " enables"},      32'({bus.out_reg_we, bus.out_mem_re, bus.out_mem_we}), 32'h0);
        check({tag, " branch_taken"}, 32'(bus.branch_taken), 32'h0);
        check({tag, " halted"},       32'(bus.halted),       32'h0);
    endtask

    function automatic logic expTake(input logic [2:0] c, input logic [2:0] f);
        logic n, z, v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        nTests = 0;
        nFail  = 0;
        clearIn();
        rst = 1'b1;
        step();
        step();
        checkReset("reset");
        rst = 1'b0;

        // Saturated ADD then EQ branch whose own ALU flags claim Z=1
        aluOp(16'h7FFF, 3'b001, 4'h3);
        step();
        check("add result", 32'(bus.result),     32'h7FFF);
        check("add flags",  32'(bus.flags),      32'h1);
        check("add reg_we", 32'(bus.out_reg_we), 32'h1);
        check("add rd",     32'(bus.out_rd),     32'h3);
        branchOp(3'b001, 16'h0100, 3'b010);
        step();
        check("eq after add taken", 32'(bus.branch_taken), 32'h0);
        check("eq after add reg_we", 32'(bus.out_reg_we), 32'h0);

        // SUB to zero, NEQ then EQ branch
        aluOp(16'h0000, 3'b010, 4'h1);
        step();
        check("sub flags", 32'(bus.flags), 32'h2);
        branchOp(3'b000, 16'h0040, 3'b010);
        step();
        check("neq taken", 32'(bus.branch_taken), 32'h0);
        branchOp(3'b001, 16'h0040, 3'b010);
        step();
        check("eq taken", 32'(bus.branch_taken), 32'h1);
        check("eq pc",    32'(bus.branch_pc),    32'h0040);
        clearIn();
        step();
        check("eq one-shot", 32'(bus.branch_taken), 32'h0);

        // UNCOND branch held three cycles by stall
        branchOp(3'b111, 16'h1234, 3'b010);
        bus.alu_dst = 16'h00AA;
        step();
        check("uncond taken", 32'(bus.branch_taken), 32'h1);
        check("uncond pc",    32'(bus.branch_pc),    32'h1234);
        aluOp(16'hABCD, 3'b101, 4'h9);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall taken",  32'(bus.branch_taken), 32'h0);
            check("stall valid",  32'(bus.out_valid),    32'h1);
            check("stall pc",     32'(bus.branch_pc),    32'h1234);
            check("stall result", 32'(bus.result),       32'h00AA);
            check("stall flags",  32'(bus.flags),        32'h2);
        end

        // flush beats stall
        aluOp(16'h5555, 3'b101, 4'h2);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step();
        check("flush valid",  32'(bus.out_valid),    32'h0);
        check("flush reg_we", 32'(bus.out_reg_we),   32'h0);
        check("flush flags",  32'(bus.flags),        32'h2);

        // store and load pass-through
        clearIn();
        bus.in_valid  = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = 16'hBEEF;
        bus.alu_dst   = 16'h8001;
        setAluFlags(3'b010);
        step();
        check("st wdata",  32'(bus.out_wdata),  32'hBEEF);
        check("st addr",   32'(bus.result),     32'h8001);
        check("st mem_we", 32'(bus.out_mem_we), 32'h1);
        bus.mem_we = 1'b0;
        bus.mem_re = 1'b1;
        bus.flush  = 1'b1;
        step();
        check("flushed ld mem_re", 32'(bus.out_mem_re), 32'h0);
        check("flushed ld mem_we", 32'(bus.out_mem_we), 32'h0);
        bus.flush = 1'b0;
        step();
        check("ld mem_re", 32'(bus.out_mem_re), 32'h1);

        // HLT then ignored ADD
        clearIn();
        bus.in_valid = 1'b1;
        bus.hlt      = 1'b1;
        setAluFlags(3'b010);
        step();
        check("hlt halted", 32'(bus.halted), 32'h1);
        aluOp(16'h1111, 3'b100, 4'h4);
        step();
        check("halt valid",  32'(bus.out_valid),  32'h0);
        check("halt halted", 32'(bus.halted),     32'h1);
        check("halt flags",  32'(bus.flags),      32'h2);
        check("halt reg_we", 32'(bus.out_reg_we), 32'h0);
        bus.stall = 1'b1;
        step();
        check("halt stall valid", 32'(bus.out_valid), 32'h0);
        rst = 1'b1;
        step();
        checkReset("halt reset");
        rst = 1'b0;

        // reset while stalling a valid entry
        aluOp(16'h4321, 3'b100, 4'h7);
        step();
        check("pre-rst valid", 32'(bus.out_valid), 32'h1);
        bus.stall = 1'b1;
        rst = 1'b1;
        step();
        checkReset("stall reset");
        rst = 1'b0;

        // every condition code against every flag value
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                aluOp(16'h0001, 3'(f), 4'h1);
                step();
                branchOp(3'(c), 16'h2000 + 16'(c), 3'(f));
                step();
                check($sformatf("cond %0d flags %0d", c, f),
                      32'(bus.branch_taken), 32'(expTake(3'(c), 3'(f))));
            end
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule : tb_ex_mem_pipe
`default_nettype wire
